// File: rtl/pe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the start-token consumer: the issue FSM state
// encoding, the width of the outstanding-invocation counter, and a helper
// that forms the "demand" (outstanding plus a pending start) used for the
// room check.
// ----------------------------------------------------------------------------
package pe_ctrl_pkg;

    // Width of the outstanding-invocation counter (holds 0..15).
    localparam int OUT_W = 4;

    // Issue FSM: IDLE drives pe_ap_start low, ISSUE drives it high.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } pe_state_e;

    // Outstanding count plus one if a start is currently pending, one bit
    // wider so the sum can never wrap.
    function automatic logic [OUT_W:0] demand(
        input logic [OUT_W-1:0] cnt,
        input logic             pending
    );
        return {1'b0, cnt} + {{OUT_W{1'b0}}, pending};
    endfunction

endpackage : pe_ctrl_pkg

// File: rtl/pe_outstanding_ctr.sv
// ----------------------------------------------------------------------------
// pe_outstanding_ctr
// Up/down counter of PE invocations that were accepted but have not yet
// completed. Never wraps in either direction.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   inc          : one invocation accepted this cycle
//   dec          : one done pulse seen this cycle
//   reserve      : a start is currently pending (counts against the limit)
//   count        : registered outstanding count
//   dec_illegal  : dec while count is zero (combinational)
//   room         : count + reserve < MAX_OUTSTANDING (combinational)
// ----------------------------------------------------------------------------
module pe_outstanding_ctr
    import pe_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             reserve,
    output logic [OUT_W-1:0] count,
    output logic             dec_illegal,
    output logic             room
);

    localparam logic [OUT_W:0]   MAX_L    = (OUT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] CNT_ZERO = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0] CNT_TOP  = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] CNT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0] count_q;
    logic [OUT_W-1:0] count_d;
    logic             dec_ok_s;
    logic             inc_ok_s;

    // Next-count computation; a decrement at zero is dropped and flagged.
    always_comb begin
        count_d     = count_q;
        dec_ok_s    = dec && (count_q != CNT_ZERO);
        dec_illegal = dec && (count_q == CNT_ZERO);
        // A simultaneous inc and legal dec nets to zero even at the top.
        inc_ok_s    = inc && ((count_q != CNT_TOP) || dec_ok_s);
        room        = (demand(count_q, reserve) < MAX_L);
        case ({inc_ok_s, dec_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            2'b11:   count_d = count_q;
            2'b00:   count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Outstanding count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pe_outstanding_ctr

// File: rtl/pe_start_token_consumer.sv
// ----------------------------------------------------------------------------
// pe_start_token_consumer
// Pops start tokens from a FIFO read port and drives the ap_ctrl_hs start
// handshake of one downstream PE, never letting more than MAX_OUTSTANDING
// invocations be in flight. Counts completions and flags done pulses that
// arrive with nothing outstanding.
//
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   if_empty_n       : FIFO has a token
//   if_read          : FIFO pop strobe (combinational)
//   if_dout          : FIFO head token
//   pe_ap_start      : PE start request (registered)
//   pe_ap_ready      : PE accepted the start
//   pe_ap_done       : PE finished one invocation (one-cycle pulse)
//   pe_token         : token of the current / last start (registered)
//   outstanding      : accepted-but-not-done invocations
//   busy             : start pending or anything outstanding
//   done_count       : completed invocations, wraps
//   err              : sticky illegal-done flag
// ----------------------------------------------------------------------------
module pe_start_token_consumer
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_empty_n,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  pe_ap_start,
    input  logic                  pe_ap_ready,
    input  logic                  pe_ap_done,
    output logic [DATA_WIDTH-1:0] pe_token,
    output logic [OUT_W-1:0]      outstanding,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  done_count,
    output logic                  err
);

    localparam logic [CNT_WIDTH-1:0] DONE_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    pe_state_e             state_q;
    pe_state_e             state_d;
    logic [DATA_WIDTH-1:0] token_q;
    logic [DATA_WIDTH-1:0] token_d;
    logic [CNT_WIDTH-1:0]  done_count_q;
    logic [CNT_WIDTH-1:0]  done_count_d;
    logic                  err_q;
    logic                  err_d;

    logic                  issue_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  room_s;
    logic                  dec_illegal_s;
    logic [OUT_W-1:0]      outstanding_s;

    pe_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_ctr (
        .clk         (ap_clk),
        .rst_n       (ap_rst_n),
        .inc         (accept_s),
        .dec         (pe_ap_done),
        .reserve     (issue_s),
        .count       (outstanding_s),
        .dec_illegal (dec_illegal_s),
        .room        (room_s)
    );

    // Pop decision and FSM / token / completion next-state logic.
    always_comb begin
        issue_s  = (state_q == ST_ISSUE);
        accept_s = issue_s && pe_ap_ready;
        // In ISSUE a new token may only replace the pending one once the PE
        // has taken it; reset forces the strobe low regardless of the FIFO.
        if (issue_s) begin
            pop_s = ap_rst_n && pe_ap_ready && if_empty_n && room_s;
        end else begin
            pop_s = ap_rst_n && if_empty_n && room_s;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (pop_s) begin
                    state_d = ST_ISSUE;
                end else if (pe_ap_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop_s) begin
            token_d = if_dout;
        end else begin
            token_d = token_q;
        end

        if (pe_ap_done && !dec_illegal_s) begin
            done_count_d = done_count_q + DONE_ONE;
        end else begin
            done_count_d = done_count_q;
        end

        err_d = err_q || dec_illegal_s;
    end

    // FSM state, token, completion counter and sticky error registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            token_q      <= {DATA_WIDTH{1'b0}};
            done_count_q <= {CNT_WIDTH{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            token_q      <= token_d;
            done_count_q <= done_count_d;
            err_q        <= err_d;
        end
    end

    assign if_read     = pop_s;
    assign pe_ap_start = (state_q == ST_ISSUE);
    assign pe_token    = token_q;
    assign outstanding = outstanding_s;
    assign busy        = (state_q == ST_ISSUE) || (outstanding_s != {OUT_W{1'b0}});
    assign done_count  = done_count_q;
    assign err         = err_q;

endmodule : pe_start_token_consumer

// File: tb/tb_pe_start_token_consumer.sv
// ----------------------------------------------------------------------------
// tb_pe_start_token_consumer
// Directed, table-driven bench for pe_start_token_consumer with
// MAX_OUTSTANDING = 2 and 4-bit tokens. Each table row is one clock cycle:
// the inputs for that cycle, the expected combinational if_read before the
// edge, and the expected registered outputs after the edge.
// ----------------------------------------------------------------------------
module tb_pe_start_token_consumer;

    localparam int DW = 4;
    localparam int CW = 32;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          if_empty_n;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          pe_ap_start;
    logic          pe_ap_ready;
    logic          pe_ap_done;
    logic [DW-1:0] pe_token;
    logic [3:0]    outstanding;
    logic          busy;
    logic [CW-1:0] done_count;
    logic          err;

    int checks;
    int errors;

    typedef struct {
        logic          e;
        logic [DW-1:0] d;
        logic          r;
        logic          dn;
        logic          rd;
        logic          st;
        logic [DW-1:0] tk;
        logic [3:0]    o;
        logic          b;
        logic [CW-1:0] c;
        logic          er;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    pe_start_token_consumer #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (2),
        .CNT_WIDTH       (CW)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .if_empty_n  (if_empty_n),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .pe_ap_start (pe_ap_start),
        .pe_ap_ready (pe_ap_ready),
        .pe_ap_done  (pe_ap_done),
        .pe_token    (pe_token),
        .outstanding (outstanding),
        .busy        (busy),
        .done_count  (done_count),
        .err         (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic vec_t mk(int e, int d, int r, int dn, int rd, int st,
                                int tk, int o, int b, int c, int er);
        vec_t v;
        v.e  = 1'(e);
        v.d  = DW'(d);
        v.r  = 1'(r);
        v.dn = 1'(dn);
        v.rd = 1'(rd);
        v.st = 1'(st);
        v.tk = DW'(tk);
        v.o  = 4'(o);
        v.b  = 1'(b);
        v.c  = CW'(c);
        v.er = 1'(er);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " pe_ap_start"}, 32'(pe_ap_start), 32'(v.st));
        chk({tag, " pe_token"},    32'(pe_token),    32'(v.tk));
        chk({tag, " outstanding"}, 32'(outstanding), 32'(v.o));
        chk({tag, " busy"},        32'(busy),        32'(v.b));
        chk({tag, " done_count"},  done_count,       v.c);
        chk({tag, " err"},         32'(err),         32'(v.er));
    endtask

    // One cycle: called 1 time unit after a rising edge.
    task automatic step(input string tag, input vec_t v);
        if_empty_n  = v.e;
        if_dout     = v.d;
        pe_ap_ready = v.r;
        pe_ap_done  = v.dn;
        #1;
        chk({tag, " if_read"}, 32'(if_read), 32'(v.rd));
        @(posedge ap_clk);
        #1;
        chk_outs(tag, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            e  d  r dn | rd st tk o  b  c  er
        vecs[0]  = mk(1, 1, 1, 0,  1, 1, 1, 0, 1, 0, 0); // pop while IDLE, ready ignored
        vecs[1]  = mk(0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 0); // accepted, FIFO empty -> IDLE
        vecs[2]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 0, 1, 0); // done
        vecs[5]  = mk(1, 2, 1, 0,  1, 1, 2, 0, 1, 1, 0); // 4 tokens queued, ready always
        vecs[6]  = mk(1, 3, 1, 0,  1, 1, 3, 1, 1, 1, 0); // back-to-back start
        vecs[7]  = mk(1, 4, 1, 0,  0, 0, 3, 2, 1, 1, 0); // limit reached
        vecs[8]  = mk(1, 4, 1, 0,  0, 0, 3, 2, 1, 1, 0); // full: no pop
        vecs[9]  = mk(1, 4, 1, 0,  0, 0, 3, 2, 1, 1, 0);
        vecs[10] = mk(1, 4, 0, 1,  0, 0, 3, 1, 1, 2, 0); // done frees room next cycle
        vecs[11] = mk(1, 4, 0, 0,  1, 1, 4, 1, 1, 2, 0); // exactly one pop
        vecs[12] = mk(1, 5, 1, 0,  0, 0, 4, 2, 1, 2, 0);
        vecs[13] = mk(1, 5, 0, 1,  0, 0, 4, 1, 1, 3, 0);
        vecs[14] = mk(1, 5, 0, 0,  1, 1, 5, 1, 1, 3, 0);
        vecs[15] = mk(1, 6, 0, 0,  0, 1, 5, 1, 1, 3, 0); // ready held off 5 cycles
        vecs[16] = mk(1, 6, 0, 0,  0, 1, 5, 1, 1, 3, 0);
        vecs[17] = mk(1, 6, 0, 0,  0, 1, 5, 1, 1, 3, 0);
        vecs[18] = mk(1, 6, 0, 0,  0, 1, 5, 1, 1, 3, 0);
        vecs[19] = mk(1, 6, 0, 0,  0, 1, 5, 1, 1, 3, 0);
        vecs[20] = mk(1, 6, 1, 1,  0, 0, 5, 1, 1, 4, 0); // ready + done, outstanding 1
        vecs[21] = mk(0, 0, 0, 1,  0, 0, 5, 0, 0, 5, 0);
        vecs[22] = mk(0, 0, 0, 1,  0, 0, 5, 0, 0, 5, 1); // illegal done
        vecs[23] = mk(1, 7, 0, 0,  1, 1, 7, 0, 1, 5, 1); // err sticky through traffic
        vecs[24] = mk(0, 0, 1, 0,  0, 0, 7, 1, 1, 5, 1);
        vecs[25] = mk(0, 0, 0, 1,  0, 0, 7, 0, 0, 6, 1);

        // Reset with a non-empty FIFO: if_read must stay low.
        ap_rst_n    = 1'b0;
        if_empty_n  = 1'b1;
        if_dout     = 4'd9;
        pe_ap_ready = 1'b0;
        pe_ap_done  = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("reset if_read", 32'(if_read), 32'd0);
        chk_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ap_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end

        // Reach ISSUE with one invocation outstanding, then reset mid-cycle.
        step("rst_a", mk(1, 8, 0, 0, 1, 1, 8, 0, 1, 6, 1));
        step("rst_b", mk(1, 9, 1, 0, 1, 1, 9, 1, 1, 6, 1));
        if_empty_n  = 1'b1;
        if_dout     = 4'd10;
        pe_ap_ready = 1'b0;
        pe_ap_done  = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst if_read", 32'(if_read), 32'd0);
        chk_outs("midrst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge ap_clk);
        #1;
        chk_outs("midrst_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ap_rst_n = 1'b1;

        // In-flight completion after release is illegal; traffic then resumes.
        step("post_a", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        step("post_b", mk(1, 3, 0, 0, 1, 1, 3, 0, 1, 0, 1));
        step("post_c", mk(0, 0, 1, 0, 0, 0, 3, 1, 1, 0, 1));
        step("post_d", mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pe_start_token_consumer
